alarm_controller: RTL
=====================

// Module: alarm_controller
// PURPOSE
//  Consumes the time-of-day produced by the seconds/minutes/hours counter chain and its 1 Hz
//  wrap pulse (sec_tick). Compares the current time against the alarm setpoint, then runs the
//  ring / snooze / stop state machine. Drives the buzzer and the status flags for the display.
// PARAMETERS
//  SNOOZE_MIN        5   snooze length in minutes (>=1); timer loads SNOOZE_MIN*60 ticks
//  RING_TIMEOUT_SEC  60  ring duration in sec_ticks (>=1) before auto-stop (missed alarm)
//  MAX_SNOOZES       3   snoozes allowed per alarm event (>=0); further snooze presses ignored
// PORTS
//  clk_in         in   1  system clock; all state changes on its rising edge
//  reset          in   1  asynchronous, active-low reset
//  sec_tick       in   1  one-cycle pulse per second, aligned with the seconds counter wrap
//  cur_hour       in   5  current hour, 0..23
//  cur_min        in   6  current minute, 0..59
//  cur_sec        in   6  current second, 0..59
//  alarm_hour     in   5  setpoint hour, 0..23
//  alarm_min      in   6  setpoint minute, 0..59
//  alarm_enable   in   1  level; low forces IDLE
//  snooze_btn     in   1  synchronized, debounced one-cycle pulse
//  stop_btn       in   1  synchronized, debounced one-cycle pulse
//  buzzer         out  1  registered; 1 Hz on/off pattern while ringing
//  ringing        out  1  registered; 1 in RINGING
//  snoozing       out  1  registered; 1 in SNOOZING
//  snoozes_left   out  $clog2(MAX_SNOOZES+1)  remaining snoozes for current event
//  missed         out  1  one-cycle pulse when ring timeout expires
// BEHAVIOUR
//  - Reset (reset=0): state=IDLE; all outputs 0 except snoozes_left=MAX_SNOOZES; counters and
//    match_q cleared. Reset mid-ring or mid-snooze aborts immediately, with no missed pulse.
//  - match = alarm_enable & hour/min equal to setpoint & cur_sec==0. match_q is match delayed
//    by one cycle. trigger = match & ~match_q. A stop inside the match second does not retrigger.
//  - Priority each cycle: ~alarm_enable > stop_btn > snooze_btn > timeout/expiry > sec_tick.
//  - IDLE: on trigger go to RINGING next cycle, with ring_cnt=0, buzzer=1, snoozes_left=MAX_SNOOZES.
//  - RINGING:
//    - sec_tick toggles buzzer and increments ring_cnt.
//    - A tick with ring_cnt==RING_TIMEOUT_SEC-1 goes to IDLE, pulses missed, and sets buzzer=0.
//    - snooze_btn with snoozes_left>0 goes to SNOOZING: snoozes_left-1, timer=SNOOZE_MIN*60,
//      buzzer=0. A same-cycle tick is discarded.
//    - snooze_btn with snoozes_left==0 is ignored.
//  - SNOOZING: sec_tick decrements the timer. The tick taking it 1->0 goes to RINGING with
//    ring_cnt=0 and buzzer=1, so snooze lasts exactly SNOOZE_MIN*60 ticks. snooze_btn is ignored.
//  - stop_btn or ~alarm_enable in RINGING/SNOOZING goes to IDLE. Outputs clear next cycle,
//    snoozes_left is restored, and there is no missed pulse.
//  - Latency: every input->output effect is exactly 1 clk_in cycle; no combinational paths.
//  - Widths: ring_cnt is $clog2(RING_TIMEOUT_SEC+1) bits, never exceeds RING_TIMEOUT_SEC-1.
//    The timer is $clog2(SNOOZE_MIN*60+1) bits, with no underflow. Comparisons are unsigned,
//    at full port width.
//  - Setpoints may change at any time; only match edges matter. Out-of-range times never match.
// STRUCTURE
//  - alarm_pkg: typedef enum logic [1:0] {IDLE, RINGING, SNOOZING} alarm_state_t;
//    HOUR_BITS=5, MIN_BITS=6, SEC_BITS=6, SEC_PER_MIN=60.
//  - Sub-module alarm_sec_timer: loadable down-counter with tick enable, load value, and a
//    zero-reached pulse. Instantiated once for the snooze timer.
//  - The FSM and ring_cnt live in the top level.
// TESTING (bench params: SNOOZE_MIN=1, RING_TIMEOUT_SEC=10, MAX_SNOOZES=2)
//  1. Alarm 07:30, time steps 07:29:59 -> 07:30:00: ringing=1, buzzer=1 one cycle after match;
//     buzzer toggles on each following tick.
//  2. No buttons: missed pulses once on the 10th tick; ringing=0, buzzer=0.
//  3. snooze_btn while ringing: snoozing=1, snoozes_left=1. After exactly 60 ticks ringing=1.
//     A second snooze gives snoozes_left=0; a third snooze is ignored (still ringing).
//  4. stop_btn and snooze_btn in the same cycle while ringing: IDLE, snoozes_left=2, no missed.
//     Holding 07:30:00 for 5 cycles causes no retrigger.
//  5. alarm_enable dropped mid-snooze: IDLE next cycle. Re-enable at 07:30:00 triggers.
//  6. reset asserted asynchronously mid-ring (between edges): outputs 0 immediately;
//     snoozes_left=2.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and time-field widths for the alarm clock's alarm controller.
package alarm_pkg;

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZING} alarm_state_t;

   localparam int HOUR_BITS   = 5;
   localparam int MIN_BITS    = 6;
   localparam int SEC_BITS    = 6;
   localparam int SEC_PER_MIN = 60;

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable seconds down-counter; done flags the enabled tick that takes the count from 1 to 0.
module alarm_sec_timer #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         done
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (tick && (count_q != {W{1'b0}})) begin
         count_d = count_q - W'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign done = tick & ~load & (count_q == W'(1));

endmodule

// File: rtl/alarm_controller.sv
// Alarm match detection and ring / snooze / stop state machine with registered display outputs.
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int SNOOZE_MIN       = 5,
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int MAX_SNOOZES      = 3,
   localparam int SL_W = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 sec_tick,
   input  logic [HOUR_BITS-1:0] cur_hour,
   input  logic [MIN_BITS-1:0]  cur_min,
   input  logic [SEC_BITS-1:0]  cur_sec,
   input  logic [HOUR_BITS-1:0] alarm_hour,
   input  logic [MIN_BITS-1:0]  alarm_min,
   input  logic                 alarm_enable,
   input  logic                 snooze_btn,
   input  logic                 stop_btn,
   output logic                 buzzer,
   output logic                 ringing,
   output logic                 snoozing,
   output logic [SL_W-1:0]      snoozes_left,
   output logic                 missed
);

   localparam int RC_W       = $clog2(RING_TIMEOUT_SEC + 1);
   localparam int TM_W       = $clog2(SNOOZE_MIN * SEC_PER_MIN + 1);
   localparam logic [RC_W-1:0] RING_LAST   = RC_W'(RING_TIMEOUT_SEC - 1);
   localparam logic [TM_W-1:0] SNOOZE_TKS  = TM_W'(SNOOZE_MIN * SEC_PER_MIN);
   localparam logic [SL_W-1:0] SNOOZE_MAX  = SL_W'(MAX_SNOOZES);

   alarm_state_t    state_q, state_d;
   logic [RC_W-1:0] ring_cnt_q, ring_cnt_d;
   logic [SL_W-1:0] snoozes_left_q, snoozes_left_d;
   logic            buzzer_q, buzzer_d;
   logic            ringing_q, ringing_d;
   logic            snoozing_q, snoozing_d;
   logic            missed_q, missed_d;
   logic            match_q, match_s, trigger_s;
   logic            timer_load_s, timer_tick_s, timer_done_s;

   // Out-of-range current or setpoint values must never produce a match.
   assign match_s = alarm_enable
                  && (cur_hour < HOUR_BITS'(24)) && (cur_min < MIN_BITS'(60))
                  && (alarm_hour < HOUR_BITS'(24)) && (alarm_min < MIN_BITS'(60))
                  && (cur_hour == alarm_hour) && (cur_min == alarm_min)
                  && (cur_sec == SEC_BITS'(0));
   assign trigger_s = match_s & ~match_q;

   alarm_sec_timer #(.W(TM_W)) u_snooze_timer (
      .clk      (clk_in),
      .rst_n    (reset),
      .load     (timer_load_s),
      .load_val (SNOOZE_TKS),
      .tick     (timer_tick_s),
      .done     (timer_done_s)
   );

   always_comb begin
      state_d        = state_q;
      ring_cnt_d     = ring_cnt_q;
      snoozes_left_d = snoozes_left_q;
      buzzer_d       = buzzer_q;
      missed_d       = 1'b0;
      timer_load_s   = 1'b0;
      timer_tick_s   = 1'b0;
      if (!alarm_enable || (stop_btn && (state_q != IDLE))) begin
         state_d        = IDLE;
         ring_cnt_d     = {RC_W{1'b0}};
         snoozes_left_d = SNOOZE_MAX;
         buzzer_d       = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (trigger_s) begin
                  state_d        = RINGING;
                  ring_cnt_d     = {RC_W{1'b0}};
                  snoozes_left_d = SNOOZE_MAX;
                  buzzer_d       = 1'b1;
               end else begin
                  buzzer_d = 1'b0;
               end
            end
            RINGING: begin
               if (snooze_btn && (snoozes_left_q != {SL_W{1'b0}})) begin
                  state_d        = SNOOZING;
                  snoozes_left_d = snoozes_left_q - SL_W'(1);
                  ring_cnt_d     = {RC_W{1'b0}};
                  buzzer_d       = 1'b0;
                  timer_load_s   = 1'b1;
               end else if (sec_tick && (ring_cnt_q == RING_LAST)) begin
                  state_d        = IDLE;
                  ring_cnt_d     = {RC_W{1'b0}};
                  snoozes_left_d = SNOOZE_MAX;
                  buzzer_d       = 1'b0;
                  missed_d       = 1'b1;
               end else if (sec_tick) begin
                  ring_cnt_d = ring_cnt_q + RC_W'(1);
                  buzzer_d   = ~buzzer_q;
               end else begin
                  state_d = RINGING;
               end
            end
            SNOOZING: begin
               timer_tick_s = sec_tick;
               if (timer_done_s) begin
                  state_d    = RINGING;
                  ring_cnt_d = {RC_W{1'b0}};
                  buzzer_d   = 1'b1;
               end else begin
                  buzzer_d = 1'b0;
               end
            end
            default: begin
               state_d        = IDLE;
               ring_cnt_d     = {RC_W{1'b0}};
               snoozes_left_d = SNOOZE_MAX;
               buzzer_d       = 1'b0;
            end
         endcase
      end
      ringing_d  = (state_d == RINGING);
      snoozing_d = (state_d == SNOOZING);
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         ring_cnt_q     <= {RC_W{1'b0}};
         snoozes_left_q <= SNOOZE_MAX;
         buzzer_q       <= 1'b0;
         ringing_q      <= 1'b0;
         snoozing_q     <= 1'b0;
         missed_q       <= 1'b0;
         match_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         ring_cnt_q     <= ring_cnt_d;
         snoozes_left_q <= snoozes_left_d;
         buzzer_q       <= buzzer_d;
         ringing_q      <= ringing_d;
         snoozing_q     <= snoozing_d;
         missed_q       <= missed_d;
         match_q        <= match_s;
      end
   end

   assign buzzer       = buzzer_q;
   assign ringing      = ringing_q;
   assign snoozing     = snoozing_q;
   assign snoozes_left = snoozes_left_q;
   assign missed       = missed_q;

endmodule
